prime_candidate_gen: RTL and testbench

Upstream feeder for the prime checker in the RSA key-generation path. On start, it draws pseudo-random odd candidates from a seeded 32-bit LFSR and hands each one to the checker through a ready/done handshake. It collects the first two distinct candidates reported prime as p and q for the modulus/totient stage. It gives up after a bounded number of attempts.

---
 rtl/prime_candidate_gen.sv | 124 ++++++++++++
 tb/tb_prime_candidate_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_candidate_gen.sv
// Prime candidate generator: draws odd, full-size candidates from a Galois LFSR, hands each to
// the prime checker over a ready/done handshake and keeps the first two distinct primes as p and q.
module prime_candidate_gen #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_TRIES = 1024,
    parameter int unsigned CHK_LAT   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] candidate,
    output logic             checker_ready,
    input  logic             checker_done,
    input  logic             checker_isprime,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
    localparam int unsigned LatW   = $clog2(CHK_LAT + 2);

    localparam logic [WIDTH-1:0]  Poly      = WIDTH'(32'h80200003);
    localparam logic [TriesW-1:0] TriesMax  = TriesW'(MAX_TRIES);
    localparam logic [LatW-1:0]   LatMax    = LatW'(CHK_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitChk,
        StEval,
        StDone,
        StFail
    } state_e;

    state_e            state;
    logic [WIDTH-1:0]  lfsr;
    logic [WIDTH-1:0]  lfsr_next;
    logic [WIDTH-1:0]  shaped;
    logic [TriesW-1:0] tries;
    logic [LatW-1:0]   lat_cnt;
    logic              have_p;
    logic              verdict;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? Poly : '0);
    // Force full size (MSB) and oddness (LSB).
    assign shaped    = {1'b1, lfsr[WIDTH-2:1], 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            lfsr          <= WIDTH'(1);
            candidate     <= '0;
            p             <= '0;
            q             <= '0;
            tries         <= '0;
            lat_cnt       <= '0;
            have_p        <= 1'b0;
            verdict       <= 1'b0;
            checker_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
        end else begin
            checker_ready <= 1'b0;
            case (state)
                StIdle, StDone, StFail: begin
                    if (start) begin
                        lfsr   <= (seed == '0) ? WIDTH'(1) : seed;
                        tries  <= '0;
                        have_p <= 1'b0;
                        p      <= '0;
                        q      <= '0;
                        done   <= 1'b0;
                        fail   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    candidate     <= shaped;
                    checker_ready <= 1'b1;
                    lfsr          <= lfsr_next;
                    tries         <= tries + 1'b1;
                    lat_cnt       <= '0;
                    state         <= StWaitChk;
                end
                StWaitChk: begin
                    // A done level left over from the previous check is ignored until the
                    // latency window has elapsed.
                    if (lat_cnt != LatMax) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else if (checker_done) begin
                        verdict <= checker_isprime;
                        state   <= StEval;
                    end
                end
                StEval: begin
                    if (verdict && !have_p) begin
                        p      <= candidate;
                        have_p <= 1'b1;
                    end
                    if (verdict && have_p && (candidate != p)) begin
                        q     <= candidate;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else if (tries == TriesMax) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StFail;
                    end else begin
                        state <= StIssue;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Bench for prime_candidate_gen: a behavioural checker answers from a verdict table and a
// plain-arithmetic reference predicts the candidate sequence and the p/q/done/fail outcome.
module tb_prime_candidate_gen;

    localparam int W  = 32;
    localparam int MT = 8;
    localparam int CL = 4;
    localparam logic [31:0] POLY = 32'h80200003;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  seed = '0;
    logic [W-1:0]  candidate;
    logic          checker_ready;
    logic          checker_done = 1'b0;
    logic          checker_isprime = 1'b0;
    logic [W-1:0]  p;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic          fail;

    int tests = 0;
    int fails = 0;

    bit          v [MT];
    bit          held_mode = 1'b0;
    bit          clear_req = 1'b0;
    logic [31:0] obs [$];
    int          ready_err = 0;
    int          n = 1000;
    int          extra = 0;
    bit          prev_ready = 1'b0;
    bit          cur_v = 1'b0;

    logic [31:0] exp_c [$];
    logic [31:0] exp_p;
    logic [31:0] exp_q;
    bit          exp_done;

    always #5 clk = ~clk;

    prime_candidate_gen #(
        .WIDTH    (W),
        .MAX_TRIES(MT),
        .CHK_LAT  (CL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .seed           (seed),
        .candidate      (candidate),
        .checker_ready  (checker_ready),
        .checker_done   (checker_done),
        .checker_isprime(checker_isprime),
        .p              (p),
        .q              (q),
        .busy           (busy),
        .done           (done),
        .fail           (fail)
    );

    // Behavioural checker: n counts cycles since the ready pulse was seen.
    always @(posedge clk) begin
        int idx;
        #2;
        if (clear_req) begin
            obs.delete();
            ready_err = 0;
        end
        if (checker_ready) begin
            if (prev_ready) ready_err++;
            else begin
                obs.push_back(candidate);
                idx   = obs.size() - 1;
                cur_v = (idx < MT) ? v[idx] : 1'b0;
                n     = 0;
                extra = $urandom_range(0, 3);
            end
        end else if (n < 1000) n++;
        prev_ready = checker_ready;
        if (held_mode) begin
            // Done stays high; the verdict flips to the real one exactly at the latency boundary.
            checker_done    = 1'b1;
            checker_isprime = (n >= CL) ? cur_v : !cur_v;
        end else begin
            checker_done    = (n >= CL + extra);
            checker_isprime = checker_done ? cur_v : 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] shape(input logic [31:0] x);
        return x | 32'h80000001;
    endfunction

    function automatic logic [31:0] get_obs(input int i);
        return (i < obs.size()) ? obs[i] : 32'hDEADBEEF;
    endfunction

    task automatic model(input logic [31:0] s);
        logic [31:0] l;
        logic [31:0] c;
        bit hp;
        exp_c.delete();
        exp_p = 0;
        exp_q = 0;
        exp_done = 0;
        hp = 0;
        l = (s == 0) ? 32'd1 : s;
        for (int i = 0; i < MT && !exp_done; i++) begin
            c = shape(l);
            exp_c.push_back(c);
            l = step(l);
            if (v[i]) begin
                if (!hp) begin
                    hp = 1;
                    exp_p = c;
                end else if (c != exp_p) begin
                    exp_q = c;
                    exp_done = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_run(input logic [31:0] s, input bit hold, input bit poke);
        int cyc;
        int bad;
        model(s);
        held_mode = hold;
        @(negedge clk);
        start = 1'b1;
        seed = s;
        clear_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_req = 1'b0;
        seed = $urandom;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        cyc = 0;
        bad = 0;
        while (!(done || fail) && cyc < 3000) begin
            start = (poke && cyc == 20);
            @(negedge clk);
            cyc++;
            if (!busy && !done && !fail) bad++;
            if (busy && (done || fail)) bad++;
        end
        start = 1'b0;
        chk("run_timeout", {31'b0, cyc < 3000}, 32'd1);
        chk("busy_vs_done", bad, 0);
        chk("done", {31'b0, done}, {31'b0, exp_done});
        chk("fail", {31'b0, fail}, {31'b0, !exp_done});
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("p", p, exp_p);
        chk("q", q, exp_q);
        chk("ready_pulses", obs.size(), exp_c.size());
        chk("ready_width", ready_err, 0);
        foreach (exp_c[i]) chk($sformatf("cand%0d", i), get_obs(i), exp_c[i]);
    endtask

    initial begin
        logic [31:0] s;
        int cyc;

        repeat (3) @(negedge clk);
        chk("rst_candidate", candidate, 32'h0);
        chk("rst_p", p, 32'h0);
        chk("rst_q", q, 32'h0);
        chk("rst_ready", {31'b0, checker_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_fail", {31'b0, fail}, 32'd0);
        reset_n = 1'b1;

        // Seed 0, never prime, plus a start pulse while busy that must be ignored.
        foreach (v[i]) v[i] = 1'b0;
        do_run(32'h0, 1'b0, 1'b1);
        chk("seed0_first", get_obs(0), 32'h80000001);
        chk("seed0_second", get_obs(1), 32'h80200003);

        // Every third candidate prime.
        foreach (v[i]) v[i] = (i % 3 == 2);
        do_run(32'h12345678, 1'b0, 1'b0);
        chk("third_is_p", p, get_obs(2));
        chk("sixth_is_q", q, get_obs(5));

        // Done held high with the verdict flipping at the latency boundary.
        for (int k = 0; k < 4; k++) begin
            foreach (v[i]) v[i] = ($urandom_range(0, 2) == 0);
            do_run($urandom, 1'b1, 1'b0);
        end

        // Seed whose first two candidates shape to the same value; the repeat must be discarded.
        foreach (v[i]) v[i] = 1'b1;
        do_run(32'hFFFFFFFE, 1'b0, 1'b0);
        chk("dup_first", get_obs(0), 32'hFFFFFFFF);
        chk("dup_second", get_obs(1), 32'hFFFFFFFF);
        chk("q_ne_p", {31'b0, q != p}, 32'd1);

        // Randomised runs with variable checker latency.
        for (int k = 0; k < 4; k++) begin
            foreach (v[i]) v[i] = ($urandom_range(0, 2) == 0);
            do_run($urandom, 1'b0, 1'b0);
        end

        // Reset in WAIT_CHK after p is found, then restart with the same seed.
        foreach (v[i]) v[i] = (i % 3 == 2);
        s = $urandom;
        model(s);
        held_mode = 1'b0;
        @(negedge clk);
        start = 1'b1;
        seed = s;
        clear_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_req = 1'b0;
        cyc = 0;
        while (obs.size() < 4 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_wait_timeout", {31'b0, cyc < 3000}, 32'd1);
        chk("mid_p_found", p, exp_p);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_p", p, 32'h0);
        chk("mid_rst_q", q, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, checker_ready}, 32'd0);
        chk("mid_rst_candidate", candidate, 32'h0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        #2;
        reset_n = 1'b1;
        do_run(s, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
